// File: rtl/io_uart_pkg.sv
// Shared types and constants for the UART transmit path.
package io_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with a head-of-queue read port; a push into a full FIFO is dropped.
module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic [WIDTH-1:0]               i_data,
    output logic [WIDTH-1:0]               o_data,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [$clog2(DEPTH+1)-1:0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rdPtr];
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_doPush && !reset) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// Buffered UART transmitter: FIFO feeds a start/data/parity/stop serializer
// whose line output is fully registered.
module io_uart_tx
    import io_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [DATA_BITS-1:0]                io_output_value,
    input  logic                                io_output_trigger,
    output logic                                io_output_ready_trigger,
    output logic                                RXD,
    output logic                                busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

    if (CLKS_PER_BIT < 2) begin : g_badClks
        $error("io_uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_badData
        $error("io_uart_tx: DATA_BITS must be 5 to 8");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_badParity
        $error("io_uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_badStop
        $error("io_uart_tx: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_badDepth
        $error("io_uart_tx: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    localparam int              BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t              r_state;
    logic [BW-1:0]          r_baudCount;
    logic [2:0]             r_bitCount;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_parity;
    logic                   r_rxd;
    logic                   r_busy;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_bitDone;
    logic                   w_frameDone;
    logic [DATA_BITS-1:0]   w_head;

    assign w_bitDone               = (r_baudCount == BAUD_LAST);
    assign w_frameDone             = (r_state == S_STOP) && w_bitDone && (r_bitCount == STOP_LAST);
    assign w_pop                   = !w_empty && ((r_state == S_IDLE) || w_frameDone);
    assign w_push                  = io_output_trigger && !w_full;
    assign io_output_ready_trigger = !w_full;
    assign RXD                     = r_rxd;
    assign busy                    = r_busy;

    io_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (io_output_value),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    // A pop always starts a fresh frame, so the back-to-back case needs no idle gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_baudCount <= '0;
            r_bitCount  <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_rxd       <= 1'b1;
            r_busy      <= 1'b0;
        end else if (w_pop) begin
            r_state     <= S_START;
            r_shift     <= w_head;
            r_parity    <= 1'b0;
            r_rxd       <= 1'b0;
            r_busy      <= 1'b1;
            r_baudCount <= '0;
            r_bitCount  <= '0;
        end else if (r_state != S_IDLE) begin
            if (!w_bitDone) begin
                r_baudCount <= r_baudCount + BW'(1);
            end else begin
                r_baudCount <= '0;
                unique case (r_state)
                    S_START: begin
                        r_state    <= S_DATA;
                        r_rxd      <= r_shift[0];
                        r_parity   <= r_parity ^ r_shift[0];
                        r_shift    <= r_shift >> 1;
                        r_bitCount <= '0;
                    end
                    S_DATA: begin
                        if (r_bitCount == DATA_LAST) begin
                            r_bitCount <= '0;
                            if (PARITY != PARITY_NONE) begin
                                r_state <= S_PARITY;
                                r_rxd   <= (PARITY == PARITY_ODD) ? ~r_parity : r_parity;
                            end else begin
                                r_state <= S_STOP;
                                r_rxd   <= 1'b1;
                            end
                        end else begin
                            r_rxd      <= r_shift[0];
                            r_parity   <= r_parity ^ r_shift[0];
                            r_shift    <= r_shift >> 1;
                            r_bitCount <= r_bitCount + 3'd1;
                        end
                    end
                    S_PARITY: begin
                        r_state    <= S_STOP;
                        r_rxd      <= 1'b1;
                        r_bitCount <= '0;
                    end
                    S_STOP: begin
                        if (r_bitCount == STOP_LAST) begin
                            r_state <= S_IDLE;
                            r_rxd   <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_bitCount <= r_bitCount + 3'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/io_uart_tx.md
IO_UART_TX -- requirements
Module: io_uart_tx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per serial bit; legal values are 2 and above.
REQ-002 The module SHALL have parameter DATA_BITS, default 8, giving payload bits per frame; legal values are 5 to 8.
REQ-003 The module SHALL have parameter PARITY, default 0, where 0 = none, 1 = even and 2 = odd.
REQ-004 The module SHALL have parameter STOP_BITS, default 1; legal values are 1 and 2.
REQ-005 The module SHALL have parameter FIFO_DEPTH, default 4, giving transmit buffer entries; it SHALL be a power of 2 and at least 2.
REQ-006 The ports SHALL be: clk, input, 1 bit, sole clock, all logic on its rising edge.
REQ-007 reset, input, 1 bit: reset is synchronous and active-high.
REQ-008 io_output_value, input, DATA_BITS: byte to send, sampled on acceptance.
REQ-009 io_output_trigger, input, 1 bit: write request.
REQ-010 io_output_ready_trigger, output, 1 bit: high when the FIFO can accept a write (not full).
REQ-011 RXD, output, 1 bit: serial line, idle high.
REQ-012 busy, output, 1 bit: high while a frame is on the line.
REQ-013 fifo_count, output, $clog2(FIFO_DEPTH+1) bits: number of queued, unsent entries.

Function
REQ-014 A write SHALL be accepted on an edge where io_output_trigger and io_output_ready_trigger are both high.
REQ-015 A write while full SHALL be ignored with no change to the FIFO, even if a pop happens in the same cycle.
REQ-016 io_output_ready_trigger SHALL equal (fifo_count != FIFO_DEPTH), combinational from registered state.
REQ-017 A simultaneous push and pop on a non-full FIFO SHALL leave fifo_count unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-019 In IDLE with fifo_count > 0, the next edge SHALL pop the head entry into the shifter, enter START, drive RXD = 0 and set busy = 1.
- A write accepted at edge N into an empty FIFO while idle gives RXD low after edge N+1.
REQ-020 Each line bit SHALL be held for exactly CLKS_PER_BIT cycles.
- The baud counter restarts at every frame start (not free-running).
REQ-021 The frame SHALL be sent in this order:
- start bit 0
- DATA_BITS data bits, LSB first
- a parity bit if PARITY != 0: even makes the total of ones even; odd makes it odd
- STOP_BITS stop bits of value 1
REQ-022 At the end of the final stop period:
- FIFO non-empty: pop and enter START on the same edge (no idle gap).
- FIFO empty: enter IDLE with busy = 0 and RXD = 1.
REQ-023 RXD SHALL be a registered output with no combinational path from any input.
REQ-024 Frame length SHALL be (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
REQ-025 Illegal parameter values SHALL cause an elaboration-time error.

Reset
REQ-026 While reset is high at an edge, the module SHALL set:
- RXD = 1
- busy = 0
- FSM = IDLE
- FIFO pointers and fifo_count = 0
- io_output_ready_trigger = 1
- baud and bit counters = 0
REQ-027 Reset asserted mid-frame SHALL abort the frame, return RXD high on the next edge and discard all queued entries.
REQ-028 A write presented during reset SHALL be ignored.

Structure
REQ-029 Package io_uart_pkg SHALL hold:
- the FSM state enum
- the parity mode constants (PARITY_NONE, PARITY_EVEN, PARITY_ODD)
REQ-030 The FIFO SHALL be a separate sub-module io_sync_fifo, parametrised by WIDTH and DEPTH, with push/pop/full/empty/count signals.
REQ-031 The serializer FSM, baud counter and parity accumulator SHALL live in io_uart_tx.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- CLKS_PER_BIT=4, 8N1: write 0xA5 -> RXD is 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; busy high for exactly 40 cycles.
- 8E1, write 0x07 -> parity bit 1; 8O1, write 0x07 -> parity bit 0; frame 44 cycles at CLKS_PER_BIT=4.
- DATA_BITS=7, STOP_BITS=2, write 0x41 -> 7 data bits, then two 1 stop bits; frame 40 cycles.
- FIFO_DEPTH=4: 6 back-to-back writes while idle -> first goes to the shifter, next 4 queue, 6th is refused while ready is low; 5 frames are sent contiguously with no idle cycle.
- Reset asserted 10 cycles into a frame with 2 queued -> RXD=1, busy=0 and fifo_count=0 the next cycle; nothing further is transmitted.
- Write on the same edge as the STOP-to-START pop with fifo_count=1 -> count stays 1; data order is preserved.
